dco_tune_ctrl: RTL and testbench
================================

# dco_tune_ctrl

Takes the 8-bit offset-binary control word from the digital loop filter and drives the DCO tuning banks of the ADPLL. It slew-limits every code change and splits the applied code into a binary coarse bank word and a thermometer fine bank word. It also runs a lock detector that tightens the slew limit once the loop settles. It sits between the loop filter output and the DCO capacitor-bank drivers, in the loop filter's clock domain.

## Interface
- CODE_W, 8: width of the filter control word (offset binary, mid-scale = 2^(CODE_W-1)).
- FINE_W, 4: LSBs of the applied code routed to the thermometer fine bank.
- SLEW_TRK, 4: maximum code step per update in TRACK.
- SLEW_LCK, 1: maximum code step per update in LOCKED.
- LOCK_TOL, 2: maximum |target − cur| counted as "in tolerance".
- UNLOCK_TOL, 6: |target − cur| above this value drops lock.
- LOCK_CNT, 64: consecutive in-tolerance updates required to declare lock.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- code_in, input, CODE_W: filter output word, offset binary.
- code_vld, input, 1: one-cycle strobe; code_in is sampled when this is high.
- coarse_bank, output, CODE_W−FINE_W: binary coarse word (applied code MSBs).
- fine_therm, output, 2^FINE_W−1: thermometer fine word; bit i = 1 iff i < applied code LSBs.
- locked, output, 1: high in LOCKED state.
- slewing, output, 1: high when the last update was clipped by the slew limit.

## Operation
- Offset-binary code_in is treated as unsigned 0..2^CODE_W−1. Sign inversion is not applied; the DCO banks use the same code sense.
- State registers:
  - cur: applied code, CODE_W unsigned.
  - state.
  - lock_cnt: saturating, wide enough for LOCK_CNT.
- diff = code_in − cur, computed signed at CODE_W+1 bits. step = diff clamped to ±SLEW, where SLEW is SLEW_TRK or SLEW_LCK according to state. cur + step always stays in range, because code_in is in range.
- FSM, evaluated only on code_vld (no change otherwise):
  - IDLE (reset state): cur = mid. On the first code_vld, cur ← code_in with no slew limit, lock_cnt ← 0, go to TRACK, slewing ← 0.
  - TRACK: cur ← cur + step (SLEW_TRK), slewing ← (|diff| > SLEW_TRK).
    - If |diff| ≤ LOCK_TOL, lock_cnt increments; otherwise lock_cnt ← 0.
    - When the increment reaches LOCK_CNT, go to LOCKED.
  - LOCKED: cur ← cur + step (SLEW_LCK), slewing ← (|diff| > SLEW_LCK).
    - If |diff| > UNLOCK_TOL, go to TRACK and set lock_cnt ← 0. That update still uses SLEW_LCK.
- |diff| is always measured against cur before the update.
- Output stage (registered, every cycle): coarse_bank ← cur[CODE_W−1:FINE_W]; fine_therm ← therm(cur[FINE_W−1:0]). Both are updated in the same cycle, so there is never a coarse/fine split word.

## Timing
- code_vld sampled at edge n → cur, state, lock_cnt, slewing updated at edge n. coarse_bank and fine_therm are updated at edge n+1, giving 2-cycle latency from code_vld high to a new bank word. locked follows state with 0 extra cycles (decoded from the state register).
- Back-to-back code_vld on every cycle is supported; each strobe is one update.
- Reset values:
  - state IDLE, cur = mid (0x80), lock_cnt 0.
  - coarse_bank = mid>>FINE_W (0x8), fine_therm 0.
  - locked 0, slewing 0.
- rst together with code_vld: rst wins and the sample is dropped.
- rst mid-lock: the block returns to IDLE and mid code on the next edge.
- Lock-count boundary: the LOCK_CNT-th consecutive in-tolerance update causes the LOCKED transition at that same edge. A single out-of-tolerance update in TRACK clears the count.

## Structure
- Package dco_tune_pkg contains:
  - State enum: IDLE, TRACK, LOCKED.
  - MID_CODE constant.
  - Function abs_diff(signed CODE_W+1).
- One sub-module, bin2therm. It is parameterized by FINE_W and is a purely combinational binary-to-thermometer decoder whose output is registered in the parent.

## Test plan
- Reset, then hold code_vld low: coarse_bank=0x8, fine_therm=0, locked=0, for all cycles.
- First code_vld with code_in=0xC3: two cycles later coarse_bank=0xC, fine_therm=0x0007; state=TRACK, slewing=0.
- In TRACK at cur=0x40, code_in=0x50 strobed every cycle: cur goes 0x44, 0x48, 0x4C, 0x50 with slewing=1,1,1,0.
- 64 consecutive strobes with code_in within ±2 of cur: locked rises at the 64th strobe edge. An outlier at the 63rd strobe delays lock by a full 64 strobes.
- LOCKED at cur=0x80, code_in=0x90: cur=0x81 and locked=0 after that edge. Subsequent steps use SLEW_TRK (0x85, …).
- rst asserted together with code_vld while LOCKED: the next edge gives outputs at mid code and state IDLE; the sample is ignored.

Source files
------------

// File: rtl/dco_tune_pkg.sv
// Shared types and helpers for the DCO tuning-word controller.
// The FSM state, the mid-scale code and the |diff| helper all live here.
package dco_tune_pkg;

    localparam int CODE_W_PKG = 8;

    localparam logic [CODE_W_PKG-1:0] MID_CODE = 8'h80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef logic signed [CODE_W_PKG:0] diff_t;

    // One extra bit keeps |-(2^CODE_W - 1)| representable without wrap.
    function automatic logic [CODE_W_PKG:0] abs_diff(input diff_t d);
        logic [CODE_W_PKG:0] r;
        if (d < 0) begin
            r = $unsigned(-d);
        end else begin
            r = $unsigned(d);
        end
        return r;
    endfunction

endpackage

// File: rtl/dco_tune_ctrl_bin2therm.sv
// Combinational binary-to-thermometer decoder for the fine capacitor bank.
// Bit i of the output is set when i is below the binary input value.
module bin2therm #(
    parameter int FINE_W = 4
) (
    input  logic [FINE_W-1:0]        i_bin,
    output logic [(1<<FINE_W)-2:0]   o_therm
);

    localparam int THERM_W = (1 << FINE_W) - 1;

    always_comb begin
        o_therm = '0;
        for (int i = 0; i < THERM_W; i++) begin
            o_therm[i] = (i_bin > FINE_W'(i));
        end
    end

endmodule

// File: rtl/dco_tune_ctrl.sv
// Slew-limited DCO tuning controller with lock detection.
// Splits the applied code into a binary coarse word and a thermometer fine word.
//
// Handshake: code_vld is a single-cycle strobe with no backpressure; every
// cycle it is high (and rst is low) is one update using that cycle's code_in.
module dco_tune_ctrl
    import dco_tune_pkg::*;
#(
    parameter int CODE_W     = CODE_W_PKG,
    parameter int FINE_W     = 4,
    parameter int SLEW_TRK   = 4,
    parameter int SLEW_LCK   = 1,
    parameter int LOCK_TOL   = 2,
    parameter int UNLOCK_TOL = 6,
    parameter int LOCK_CNT   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CODE_W-1:0]           code_in,
    input  logic                        code_vld,
    output logic [CODE_W-FINE_W-1:0]    coarse_bank,
    output logic [(1<<FINE_W)-2:0]      fine_therm,
    output logic                        locked,
    output logic                        slewing,
    output state_t                      dbg_state
);

    localparam int CNT_W   = $clog2(LOCK_CNT + 1);
    localparam int THERM_W = (1 << FINE_W) - 1;

    state_t                     r_state;
    logic [CODE_W-1:0]          r_cur;
    logic [CNT_W-1:0]           r_lock_cnt;
    logic                       r_slewing;
    logic [CODE_W-FINE_W-1:0]   r_coarse;
    logic [THERM_W-1:0]         r_fine;

    logic signed [CODE_W:0]     w_diff;
    logic signed [CODE_W:0]     w_slew;
    logic signed [CODE_W:0]     w_step;
    logic [CODE_W:0]            w_abs;
    logic [CODE_W-1:0]          w_cur_next;
    logic                       w_clip;
    logic                       w_in_tol;
    logic                       w_out_tol;
    logic [CNT_W-1:0]           w_cnt_inc;
    logic [THERM_W-1:0]         w_therm;

    // Step toward the target, clamped to the slew limit of the current state.
    always_comb begin
        w_diff = $signed({1'b0, code_in}) - $signed({1'b0, r_cur});
        w_abs  = abs_diff(w_diff);
        w_slew = (r_state == LOCKED) ? (CODE_W+1)'(SLEW_LCK) : (CODE_W+1)'(SLEW_TRK);
        if (w_diff > w_slew) begin
            w_step = w_slew;
        end else if (w_diff < -w_slew) begin
            w_step = -w_slew;
        end else begin
            w_step = w_diff;
        end
        w_cur_next = r_cur + w_step[CODE_W-1:0];
        w_clip     = (w_abs > $unsigned(w_slew));
        w_in_tol   = (w_abs <= (CODE_W+1)'(LOCK_TOL));
        w_out_tol  = (w_abs > (CODE_W+1)'(UNLOCK_TOL));
        if (r_lock_cnt == CNT_W'(LOCK_CNT)) begin
            w_cnt_inc = r_lock_cnt;
        end else begin
            w_cnt_inc = r_lock_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cur      <= MID_CODE;
            r_lock_cnt <= '0;
            r_slewing  <= 1'b0;
        end else if (code_vld) begin
            case (r_state)
                IDLE: begin
                    r_cur      <= code_in;
                    r_lock_cnt <= '0;
                    r_slewing  <= 1'b0;
                    r_state    <= TRACK;
                end
                TRACK: begin
                    r_cur     <= w_cur_next;
                    r_slewing <= w_clip;
                    if (w_in_tol) begin
                        r_lock_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(LOCK_CNT)) begin
                            r_state <= LOCKED;
                        end
                    end else begin
                        r_lock_cnt <= '0;
                    end
                end
                LOCKED: begin
                    // The unlocking update still moves by the locked slew.
                    r_cur     <= w_cur_next;
                    r_slewing <= w_clip;
                    if (w_out_tol) begin
                        r_state    <= TRACK;
                        r_lock_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    bin2therm #(
        .FINE_W (FINE_W)
    ) u_bin2therm (
        .i_bin   (r_cur[FINE_W-1:0]),
        .o_therm (w_therm)
    );

    // Coarse and fine are registered together so the banks never see a split word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coarse <= MID_CODE[CODE_W-1:FINE_W];
            r_fine   <= '0;
        end else begin
            r_coarse <= r_cur[CODE_W-1:FINE_W];
            r_fine   <= w_therm;
        end
    end

    assign coarse_bank = r_coarse;
    assign fine_therm  = r_fine;
    assign locked      = (r_state == LOCKED);
    assign slewing     = r_slewing;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Scoreboard bench for dco_tune_ctrl: a behavioural model predicts each update,
// and expectations are queued at drive time and checked when the DUT responds.
module tb_dco_tune_ctrl;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [7:0]            code_in = 8'h00;
    logic                  code_vld = 1'b0;
    logic [3:0]            coarse_bank;
    logic [14:0]           fine_therm;
    logic                  locked;
    logic                  slewing;
    dco_tune_pkg::state_t  dbg_state;

    int checks = 0;
    int errors = 0;

    int m_cur;
    int m_state;
    int m_cnt;
    bit m_slew;

    logic [18:0] bank_q[$];
    logic [3:0]  flag_q[$];
    logic        s1 = 1'b0;
    logic        s2 = 1'b0;

    dco_tune_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .code_vld    (code_vld),
        .coarse_bank (coarse_bank),
        .fine_therm  (fine_therm),
        .locked      (locked),
        .slewing     (slewing),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] therm_of(input int n);
        logic [14:0] t;
        t = '0;
        for (int i = 0; i < n; i++) t[i] = 1'b1;
        return t;
    endfunction

    task automatic model_reset();
        m_cur   = 128;
        m_state = 0;
        m_cnt   = 0;
        m_slew  = 1'b0;
    endtask

    task automatic model_update(input int code);
        int d, ad, sl, st;
        if (m_state == 0) begin
            m_cur   = code;
            m_cnt   = 0;
            m_state = 1;
            m_slew  = 1'b0;
        end else begin
            d  = code - m_cur;
            ad = (d < 0) ? -d : d;
            sl = (m_state == 2) ? 1 : 4;
            st = (d > sl) ? sl : ((d < -sl) ? -sl : d);
            m_slew = (ad > sl);
            m_cur  = m_cur + st;
            if (m_state == 1) begin
                if (ad <= 2) begin
                    m_cnt++;
                    if (m_cnt == 64) m_state = 2;
                end else begin
                    m_cnt = 0;
                end
            end else if (ad > 6) begin
                m_state = 1;
                m_cnt   = 0;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the sampling edge.
    task automatic strobe(input int code);
        code_in  = 8'(code);
        code_vld = 1'b1;
        model_update(code);
        bank_q.push_back({4'(m_cur >> 4), therm_of(m_cur % 16)});
        flag_q.push_back({2'(m_state), (m_state == 2), m_slew});
        @(negedge clk);
        code_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int near_code(input int spread);
        int c;
        c = m_cur + $urandom_range(0, 2 * spread) - spread;
        if (c < 0) c = 0;
        if (c > 255) c = 255;
        return c;
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        code_vld = 1'b0;
        idle(2);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain(input string tag);
        idle(3);
        checks++;
        if (bank_q.size() != 0 || flag_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: pending bank=%0d flags=%0d, required 0/0",
                     tag, bank_q.size(), flag_q.size());
        end
    endtask

    always @(posedge clk) begin
        s1 <= code_vld && !rst;
        s2 <= s1 && !rst;
    end

    always @(negedge clk) begin
        logic [3:0]  f;
        logic [18:0] b;
        if (s1) begin
            checks++;
            if (flag_q.size() == 0) begin
                errors++;
                $display("FAIL flags: unexpected update, no expectation queued");
            end else begin
                f = flag_q.pop_front();
                if ({2'(dbg_state), locked, slewing} !== f) begin
                    errors++;
                    $display("FAIL flags: state/locked/slewing got %b required %b",
                             {2'(dbg_state), locked, slewing}, f);
                end
            end
        end
        if (s2) begin
            checks++;
            if (bank_q.size() == 0) begin
                errors++;
                $display("FAIL bank: unexpected bank word, no expectation queued");
            end else begin
                b = bank_q.pop_front();
                if ({coarse_bank, fine_therm} !== b) begin
                    errors++;
                    $display("FAIL bank: coarse/fine got %h/%h required %h/%h",
                             coarse_bank, fine_therm, b[18:15], b[14:0]);
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({coarse_bank, fine_therm, locked, slewing, 2'(dbg_state)} !==
                {4'h8, 15'h0000, 1'b0, 1'b0, 2'd0}) begin
                errors++;
                $display("FAIL reset_idle: coarse=%h fine=%h locked=%b slewing=%b state=%0d, required 8/0000/0/0/0",
                         coarse_bank, fine_therm, locked, slewing, dbg_state);
            end
        end
    endtask

    task automatic test_first_code();
        strobe(8'hC3);
        idle(1);
        checks++;
        if (coarse_bank !== 4'hC || fine_therm !== 15'h0007 ||
            2'(dbg_state) !== 2'd1 || slewing !== 1'b0) begin
            errors++;
            $display("FAIL first_code: coarse=%h fine=%h state=%0d slewing=%b, required C/0007/1/0",
                     coarse_bank, fine_therm, dbg_state, slewing);
        end
        drain("first_code");
    endtask

    task automatic test_slew();
        logic [3:0] exp_sl;
        exp_sl = 4'b0111;
        do_reset();
        strobe(8'h40);
        for (int i = 0; i < 4; i++) begin
            strobe(8'h50);
            checks++;
            if (slewing !== exp_sl[i]) begin
                errors++;
                $display("FAIL slew_step%0d: slewing=%b required %b", i, slewing, exp_sl[i]);
            end
        end
        idle(1);
        checks++;
        if (coarse_bank !== 4'h5 || fine_therm !== 15'h0000) begin
            errors++;
            $display("FAIL slew_final: coarse=%h fine=%h required 5/0000", coarse_bank, fine_therm);
        end
        drain("slew");
    endtask

    task automatic test_lock();
        for (int i = 0; i < 62; i++) strobe(near_code(2));
        strobe(m_cur + 5);
        for (int i = 0; i < 63; i++) strobe(near_code(2));
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: locked=%b required 0 after 63 in-tolerance strobes", locked);
        end
        strobe(near_code(2));
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_at_64: locked=%b required 1", locked);
        end
        drain("lock");
    endtask

    task automatic lock_at_mid();
        do_reset();
        strobe(8'h80);
        for (int i = 0; i < 64; i++) strobe(8'h80);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_mid: locked=%b required 1", locked);
        end
    endtask

    task automatic test_unlock();
        lock_at_mid();
        strobe(8'h90);
        checks++;
        if (locked !== 1'b0 || slewing !== 1'b1 || 2'(dbg_state) !== 2'd1) begin
            errors++;
            $display("FAIL unlock: locked=%b slewing=%b state=%0d required 0/1/1",
                     locked, slewing, dbg_state);
        end
        strobe(8'h90);
        checks++;
        if (coarse_bank !== 4'h8 || fine_therm !== 15'h0001) begin
            errors++;
            $display("FAIL unlock_lck_step: coarse=%h fine=%h required 8/0001", coarse_bank, fine_therm);
        end
        idle(1);
        checks++;
        if (coarse_bank !== 4'h8 || fine_therm !== 15'h001F) begin
            errors++;
            $display("FAIL unlock_trk_step: coarse=%h fine=%h required 8/001F", coarse_bank, fine_therm);
        end
        drain("unlock");
    endtask

    task automatic test_rst_with_vld();
        lock_at_mid();
        drain("prelock");
        rst      = 1'b1;
        code_vld = 1'b1;
        code_in  = 8'h20;
        @(negedge clk);
        rst      = 1'b0;
        code_vld = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({coarse_bank, fine_therm, locked, slewing, 2'(dbg_state)} !==
                {4'h8, 15'h0000, 1'b0, 1'b0, 2'd0}) begin
                errors++;
                $display("FAIL rst_vld_c%0d: coarse=%h fine=%h locked=%b slewing=%b state=%0d, required 8/0000/0/0/0",
                         i, coarse_bank, fine_therm, locked, slewing, dbg_state);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else if ($urandom_range(0, 9) < 8) begin
                strobe(near_code(3));
            end else begin
                strobe($urandom_range(0, 255));
            end
        end
        drain("b2b");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_code();
        test_slew();
        test_lock();
        test_unlock();
        test_rst_with_vld();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
